// File: rtl/pipe_stage_bank.sv
// Pipeline-boundary register bank: DEPTH cascaded data/ctrl/valid stages with
// stall/flush control and saturating stall, flush and retire event counters.
module pipe_stage_bank #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 9,
    parameter int                DEPTH    = 1,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] din_data,
    input  logic [CTRL_W-1:0] din_ctrl,
    input  logic              din_valid,
    output logic [DATA_W-1:0] dout_data,
    output logic [CTRL_W-1:0] dout_ctrl,
    output logic              dout_valid,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_stage_bank: DEPTH must be in 1..4");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] data_p [DEPTH];
    logic [CTRL_W-1:0] ctrl_p [DEPTH];
    logic [DEPTH-1:0]  vld_p;

    logic do_flush;
    logic do_stall;
    logic advance;

    // Flush outranks stall; both are gated by the global enable.
    assign do_flush = enable & flush;
    assign do_stall = enable & ~flush & stall;
    assign advance  = enable & ~flush & ~stall;

    // Stage 0: capture from din; a bubble never carries live control.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            data_p[0] <= '0;
            ctrl_p[0] <= NOP_CTRL;
            vld_p[0]  <= 1'b0;
        end else if (do_flush) begin
            data_p[0] <= '0;
            ctrl_p[0] <= NOP_CTRL;
            vld_p[0]  <= 1'b0;
        end else if (advance) begin
            data_p[0] <= din_data;
            ctrl_p[0] <= din_valid ? din_ctrl : NOP_CTRL;
            vld_p[0]  <= din_valid;
        end
    end

    // Stages 1..DEPTH-1: shift from the previous stage.
    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                data_p[g] <= '0;
                ctrl_p[g] <= NOP_CTRL;
                vld_p[g]  <= 1'b0;
            end else if (do_flush) begin
                data_p[g] <= '0;
                ctrl_p[g] <= NOP_CTRL;
                vld_p[g]  <= 1'b0;
            end else if (advance) begin
                data_p[g] <= data_p[g-1];
                ctrl_p[g] <= vld_p[g-1] ? ctrl_p[g-1] : NOP_CTRL;
                vld_p[g]  <= vld_p[g-1];
            end
        end
    end

    // Event counters follow the same enable/flush/stall priority as the stages.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (do_flush)
                flush_cnt <= sat_inc(flush_cnt);
            if (do_stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (advance && vld_p[DEPTH-1])
                retire_cnt <= sat_inc(retire_cnt);
        end
    end

    assign dout_data   = data_p[DEPTH-1];
    assign dout_ctrl   = ctrl_p[DEPTH-1];
    assign dout_valid  = vld_p[DEPTH-1];
    assign stage_valid = vld_p;

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed bench for pipe_stage_bank: three instances (DEPTH=2, DEPTH=3,
// DEPTH=2 with 3-bit counters) share one stimulus stream.
module tb_pipe_stage_bank;

    logic        clk;
    logic        arst;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [31:0] din_data;
    logic [8:0]  din_ctrl;
    logic        din_valid;

    logic [31:0] a_data;   logic [8:0] a_ctrl;   logic a_valid;   logic [1:0] a_sv;
    logic [15:0] a_scnt, a_fcnt, a_rcnt;
    logic [31:0] b_data;   logic [8:0] b_ctrl;   logic b_valid;   logic [2:0] b_sv;
    logic [15:0] b_scnt, b_fcnt, b_rcnt;
    logic [31:0] c_data;   logic [8:0] c_ctrl;   logic c_valid;   logic [1:0] c_sv;
    logic [2:0]  c_scnt, c_fcnt, c_rcnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_stage_bank #(.DATA_W(32), .CTRL_W(9), .DEPTH(2), .NOP_CTRL(9'h000), .CNT_W(16)) u_d2 (
        .clk(clk), .arst(arst), .enable(enable), .stall(stall), .flush(flush),
        .din_data(din_data), .din_ctrl(din_ctrl), .din_valid(din_valid),
        .dout_data(a_data), .dout_ctrl(a_ctrl), .dout_valid(a_valid), .stage_valid(a_sv),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt), .retire_cnt(a_rcnt));

    pipe_stage_bank #(.DATA_W(32), .CTRL_W(9), .DEPTH(3), .NOP_CTRL(9'h000), .CNT_W(16)) u_d3 (
        .clk(clk), .arst(arst), .enable(enable), .stall(stall), .flush(flush),
        .din_data(din_data), .din_ctrl(din_ctrl), .din_valid(din_valid),
        .dout_data(b_data), .dout_ctrl(b_ctrl), .dout_valid(b_valid), .stage_valid(b_sv),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt), .retire_cnt(b_rcnt));

    pipe_stage_bank #(.DATA_W(32), .CTRL_W(9), .DEPTH(2), .NOP_CTRL(9'h000), .CNT_W(3)) u_c3 (
        .clk(clk), .arst(arst), .enable(enable), .stall(stall), .flush(flush),
        .din_data(din_data), .din_ctrl(din_ctrl), .din_valid(din_valid),
        .dout_data(c_data), .dout_ctrl(c_ctrl), .dout_valid(c_valid), .stage_valid(c_sv),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt), .retire_cnt(c_rcnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0;
        din_data = '0; din_ctrl = '0; din_valid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_d2_valid", a_valid, 0);
        chk("rst_d2_ctrl",  a_ctrl, 9'h000);
        chk("rst_d2_sv",    a_sv, 2'b00);
        chk("rst_d3_data",  b_data, 0);
        chk("rst_d3_rcnt",  b_rcnt, 0);
        arst = 1'b0;

        // DEPTH=3 streaming: A0 appears on the 3rd edge, 3 retires after 6 edges
        for (int n = 0; n < 6; n++) begin
            din_data = 32'hA0 + n; din_ctrl = 9'(n + 1); din_valid = 1'b1;
            tick();
            if (n >= 2) begin
                chk("d3_stream_data", b_data, 32'hA0 + n - 2);
                chk("d3_stream_ctrl", b_ctrl, n - 1);
                chk("d3_stream_valid", b_valid, 1);
            end else begin
                chk("d3_stream_empty", b_valid, 0);
            end
        end
        chk("d3_retire_cnt", b_rcnt, 3);

        // Fill DEPTH=2 control with 0x1FF, then reset asynchronously mid-cycle
        din_data = 32'hBB; din_ctrl = 9'h1FF; din_valid = 1'b1;
        tick(); tick();
        chk("d2_pre_rst_ctrl", a_ctrl, 9'h1FF);
        chk("d2_pre_rst_rcnt", a_rcnt, 6);
        #2 arst = 1'b1;
        #1;
        chk("arst_d2_data",  a_data, 0);
        chk("arst_d2_ctrl",  a_ctrl, 9'h000);
        chk("arst_d2_valid", a_valid, 0);
        chk("arst_d2_sv",    a_sv, 2'b00);
        chk("arst_d2_rcnt",  a_rcnt, 0);
        chk("arst_d2_scnt",  a_scnt, 0);
        chk("arst_d2_fcnt",  a_fcnt, 0);
        tick();
        chk("arst_hold_sv", a_sv, 2'b00);
        arst = 1'b0;

        // DEPTH=2 stall: stage1=0x22, stage0=0x11, hold 4 cycles
        din_data = 32'h22; din_ctrl = 9'h0A5; din_valid = 1'b1; tick();
        din_data = 32'h11; tick();
        chk("d2_full_data", a_data, 32'h22);
        stall = 1'b1; din_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold_data", a_data, 32'h22);
        end
        chk("stall_cnt4", a_scnt, 4);
        stall = 1'b0;
        tick();
        chk("stall_release_data", a_data, 32'h11);
        chk("stall_release_rcnt", a_rcnt, 1);
        chk("stall_release_ctrl", a_ctrl, 9'h0A5);

        // Flush and stall together: flush wins, nothing retires
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_sv",    a_sv, 2'b00);
        chk("flush_ctrl",  a_ctrl, 9'h000);
        chk("flush_data",  a_data, 0);
        chk("flush_fcnt",  a_fcnt, 1);
        chk("flush_scnt",  a_scnt, 4);
        chk("flush_rcnt",  a_rcnt, 1);
        stall = 1'b0; flush = 1'b0;

        // Refill, then freeze with enable=0 while toggling inputs
        din_data = 32'h44; din_valid = 1'b1; tick();
        chk("refill_sv01", a_sv, 2'b01);
        din_data = 32'h55; tick();
        chk("refill_sv11", a_sv, 2'b11);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_data  = 32'(i * 7);
            din_valid = i[0];
            stall     = i[0];
            flush     = i[1];
            tick();
            chk("frz_data", a_data, 32'h44);
            chk("frz_sv",   a_sv, 2'b11);
            chk("frz_cnts", {a_scnt, a_fcnt, a_rcnt}, {16'd4, 16'd1, 16'd1});
        end
        enable = 1'b1; stall = 1'b0; flush = 1'b0;

        // Saturation on 3-bit counter over 10 stall cycles
        #2 arst = 1'b1;
        tick();
        arst = 1'b0;
        stall = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("sat_c3_scnt", c_scnt, (i > 7) ? 7 : i);
            chk("sat_d2_scnt", a_scnt, i);
        end
        stall = 1'b0;

        // Invalid input with live-looking control is captured as NOP
        din_data = 32'h77; din_ctrl = 9'h1FF; din_valid = 1'b0;
        tick();
        chk("inv_sv0", a_sv, 2'b00);
        din_ctrl = 9'h000;
        tick();
        chk("inv_ctrl",  a_ctrl, 9'h000);
        chk("inv_data",  a_data, 32'h77);
        chk("inv_valid", a_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
